// File: rtl/txn_guard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | txn_guard: per-ID outstanding-transaction watchdog for one AXI req/rsp pair |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module txn_guard #(
   parameter int IdWidth       = 4,
   parameter int NumEntries    = 8,
   parameter int MaxTxnsPerId  = 8,
   parameter int CntWidth      = 16,
   parameter int PrescaleWidth = 4,
   parameter int ReadMode      = 0
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic                                          en_i,
   input  logic [CntWidth-1:0]                           budget_i,
   input  logic [PrescaleWidth-1:0]                      prescale_i,
   input  logic                                          req_valid_i,
   input  logic                                          req_ready_i,
   input  logic [IdWidth-1:0]                            req_id_i,
   input  logic                                          rsp_valid_i,
   input  logic                                          rsp_ready_i,
   input  logic [IdWidth-1:0]                            rsp_id_i,
   input  logic                                          rsp_last_i,
   input  logic                                          clear_i,
   output logic                                          stall_o,
   output logic                                          reset_req_o,
   output logic                                          irq_o,
   output logic [1:0]                                    err_cause_o,
   output logic [IdWidth-1:0]                            err_id_o,
   output logic [$clog2(NumEntries*MaxTxnsPerId+1)-1:0]  outstanding_o
);
   localparam int         c_out_w       = $clog2(NumEntries*MaxTxnsPerId+1);
   localparam int         c_cnt_w       = $clog2(MaxTxnsPerId+1);
   localparam int         c_idx_w       = $clog2(NumEntries);
   localparam logic [1:0] c_cause_to    = 2'b01;
   localparam logic [1:0] c_cause_unexp = 2'b10;
   localparam logic [1:0] c_cause_ovf   = 2'b11;

   logic [NumEntries-1:0]    r_valid;
   logic [IdWidth-1:0]       r_id     [NumEntries];
   logic [c_cnt_w-1:0]       r_count  [NumEntries];
   logic [CntWidth-1:0]      r_budget [NumEntries];
   logic [PrescaleWidth-1:0] r_presc;
   logic                     r_err;
   logic [1:0]               r_cause;
   logic [IdWidth-1:0]       r_err_id;
   logic [c_out_w-1:0]       r_out;

   logic [NumEntries-1:0] w_req_hit, w_rsp_hit, w_full, w_cpl, w_dec, w_to;
   logic                  w_req_acc, w_rsp_acc, w_tick, w_dec_en, w_any_free;
   logic                  w_req_any, w_req_full, w_ovf, w_unexp, w_req_ok, w_alloc_new;
   logic [c_idx_w-1:0]    w_free_idx, w_to_idx;

   assign w_req_acc = req_valid_i & req_ready_i & en_i & ~r_err;
   assign w_rsp_acc = rsp_valid_i & rsp_ready_i & en_i & ~r_err &
                      ((ReadMode != 0) ? rsp_last_i : 1'b1);
   assign w_tick    = (r_presc == prescale_i);
   assign w_dec_en  = w_tick & en_i & ~r_err & (budget_i != '0);

   for (genvar g = 0; g < NumEntries; g++) begin : g_match
      assign w_req_hit[g] = r_valid[g] && (r_id[g] == req_id_i);
      assign w_rsp_hit[g] = r_valid[g] && (r_id[g] == rsp_id_i);
      assign w_full[g]    = (r_count[g] == c_cnt_w'(MaxTxnsPerId));
      assign w_cpl[g]     = w_rsp_acc & w_rsp_hit[g];
      // a completing entry is reloaded instead of aged this cycle
      assign w_dec[g]     = w_dec_en & r_valid[g] & ~w_cpl[g];
      assign w_to[g]      = w_dec[g] & (r_budget[g] == CntWidth'(1));
   end

   assign w_req_any   = |w_req_hit;
   assign w_req_full  = |(w_req_hit & w_full);
   assign w_any_free  = ~&r_valid;
   assign stall_o     = w_req_full | (~w_req_any & ~w_any_free);
   assign w_ovf       = w_req_acc & stall_o;
   assign w_req_ok    = w_req_acc & ~stall_o;
   assign w_alloc_new = w_req_ok & ~w_req_any;
   assign w_unexp     = w_rsp_acc & ~|w_rsp_hit;

   always_comb begin
      w_free_idx = '0;
      w_to_idx   = '0;
      for (int i = NumEntries - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = c_idx_w'(i);
         if (w_to[i])     w_to_idx   = c_idx_w'(i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         for (int i = 0; i < NumEntries; i++) begin
            r_id[i]     <= '0;
            r_count[i]  <= '0;
            r_budget[i] <= '0;
         end
      end else if (clear_i) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < NumEntries; i++) begin
            if (w_alloc_new && (w_free_idx == c_idx_w'(i))) begin
               r_valid[i]  <= 1'b1;
               r_id[i]     <= req_id_i;
               r_count[i]  <= c_cnt_w'(1);
               r_budget[i] <= budget_i;
            end else if (w_cpl[i]) begin
               // same-ID request and completion cancel; entry survives even at count 1
               if (w_req_ok && w_req_hit[i]) begin
                  r_budget[i] <= budget_i;
               end else if (r_count[i] == c_cnt_w'(1)) begin
                  r_valid[i] <= 1'b0;
               end else begin
                  r_count[i]  <= r_count[i] - 1'b1;
                  r_budget[i] <= budget_i;
               end
            end else begin
               if (w_req_ok && w_req_hit[i]) r_count[i] <= r_count[i] + 1'b1;
               if (w_dec[i] && (r_budget[i] != '0)) r_budget[i] <= r_budget[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_presc  <= '0;
         r_err    <= 1'b0;
         r_cause  <= 2'b00;
         r_err_id <= '0;
         r_out    <= '0;
      end else if (clear_i) begin
         r_presc  <= '0;
         r_err    <= 1'b0;
         r_cause  <= 2'b00;
         r_err_id <= '0;
         r_out    <= '0;
      end else begin
         if (!r_err) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (|w_to) begin
               r_err    <= 1'b1;
               r_cause  <= c_cause_to;
               r_err_id <= r_id[w_to_idx];
            end else if (w_ovf) begin
               r_err    <= 1'b1;
               r_cause  <= c_cause_ovf;
               r_err_id <= req_id_i;
            end else if (w_unexp) begin
               r_err    <= 1'b1;
               r_cause  <= c_cause_unexp;
               r_err_id <= rsp_id_i;
            end
         end
         r_out <= r_out + c_out_w'(w_req_ok) - c_out_w'(|w_cpl);
      end
   end

   assign reset_req_o   = r_err;
   assign irq_o         = r_err;
   assign err_cause_o   = r_cause;
   assign err_id_o      = r_err_id;
   assign outstanding_o = r_out;

endmodule
`default_nettype wire

// File: tb/tb_txn_guard.sv
`default_nettype none
// Bench for txn_guard: write- and read-mode instances share one directed stimulus,
// each checked every cycle against a per-ID table model, plus hand-computed pins.
module tb_txn_guard;
   localparam int c_max = 8;
   localparam int c_ne  = 8;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1, clear = 1'b0;
   logic [15:0] budget = 16'd5;
   logic [3:0] prescale = 4'd0;
   logic       req_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, rsp_ready = 1'b0;
   logic       rsp_last = 1'b0;
   logic [3:0] req_id = 4'd0, rsp_id = 4'd0;

   logic       st_w, rr_w, irq_w, st_r, rr_r, irq_r;
   logic [1:0] ca_w, ca_r;
   logic [3:0] ei_w, ei_r;
   logic [6:0] out_w, out_r;

   int n_checks = 0;
   int n_fail   = 0;

   txn_guard #(.ReadMode(0)) dut_w (
      .clk_i(clk), .rst_i(rst), .en_i(en), .budget_i(budget), .prescale_i(prescale),
      .req_valid_i(req_valid), .req_ready_i(req_ready), .req_id_i(req_id),
      .rsp_valid_i(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_i(rsp_id),
      .rsp_last_i(rsp_last), .clear_i(clear), .stall_o(st_w), .reset_req_o(rr_w),
      .irq_o(irq_w), .err_cause_o(ca_w), .err_id_o(ei_w), .outstanding_o(out_w));

   txn_guard #(.ReadMode(1)) dut_r (
      .clk_i(clk), .rst_i(rst), .en_i(en), .budget_i(budget), .prescale_i(prescale),
      .req_valid_i(req_valid), .req_ready_i(req_ready), .req_id_i(req_id),
      .rsp_valid_i(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_i(rsp_id),
      .rsp_last_i(rsp_last), .clear_i(clear), .stall_o(st_r), .reset_req_o(rr_r),
      .irq_o(irq_r), .err_cause_o(ca_r), .err_id_o(ei_r), .outstanding_o(out_r));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // model: per-instance table of {valid, id, count, budget} slots
   bit m_v   [2][c_ne];
   int m_id  [2][c_ne];
   int m_cnt [2][c_ne];
   int m_bud [2][c_ne];
   int m_presc [2];
   bit m_err   [2];
   int m_cause [2];
   int m_eid   [2];

   task automatic m_reset(input int d);
      for (int i = 0; i < c_ne; i++) begin
         m_v[d][i] = 0; m_id[d][i] = 0; m_cnt[d][i] = 0; m_bud[d][i] = 0;
      end
      m_presc[d] = 0; m_err[d] = 0; m_cause[d] = 0; m_eid[d] = 0;
   endtask

   function automatic int m_find(input int d, input int id);
      for (int i = 0; i < c_ne; i++) if (m_v[d][i] && m_id[d][i] == id) return i;
      return -1;
   endfunction

   task automatic m_step(input int d);
      bit rq, rs, tick, ovf, unexp;
      int ri, si, fr, to;
      if (clear) begin m_reset(d); return; end
      if (m_err[d]) return;
      rq   = req_valid & req_ready & en;
      rs   = rsp_valid & rsp_ready & en & ((d == 1) ? rsp_last : 1'b1);
      tick = (m_presc[d] == int'(prescale));
      ri   = m_find(d, int'(req_id));
      si   = rs ? m_find(d, int'(rsp_id)) : -1;
      fr   = -1;
      for (int i = c_ne - 1; i >= 0; i--) if (!m_v[d][i]) fr = i;
      ovf   = rq && ((ri >= 0) ? (m_cnt[d][ri] == c_max) : (fr < 0));
      unexp = rs && (si < 0);
      to    = -1;
      if (tick && en && budget != 0)
         for (int i = 0; i < c_ne; i++)
            if (m_v[d][i] && i != si) begin
               if (m_bud[d][i] == 1 && to < 0) to = i;
               if (m_bud[d][i] > 0) m_bud[d][i]--;
            end
      if (rq && !ovf) begin
         if (ri >= 0) m_cnt[d][ri]++;
         else begin
            m_v[d][fr] = 1; m_id[d][fr] = int'(req_id);
            m_cnt[d][fr] = 1; m_bud[d][fr] = int'(budget);
         end
      end
      if (si >= 0) begin
         m_cnt[d][si]--;
         if (m_cnt[d][si] == 0) m_v[d][si] = 0;
         else m_bud[d][si] = int'(budget);
      end
      if (to >= 0)    begin m_err[d] = 1; m_cause[d] = 1; m_eid[d] = m_id[d][to]; end
      else if (ovf)   begin m_err[d] = 1; m_cause[d] = 3; m_eid[d] = int'(req_id); end
      else if (unexp) begin m_err[d] = 1; m_cause[d] = 2; m_eid[d] = int'(rsp_id); end
      m_presc[d] = tick ? 0 : (m_presc[d] + 1) % 16;
   endtask

   initial begin
      m_reset(0); m_reset(1);
      forever begin
         @(posedge clk or posedge rst);
         for (int d = 0; d < 2; d++) begin
            if (rst) m_reset(d);
            else m_step(d);
         end
      end
   end

   // every-cycle comparison of both instances against the model
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int    sum, ri, nv;
         bit    es;
         string p;
         p   = (d == 0) ? "wr" : "rd";
         sum = 0; nv = 0;
         for (int i = 0; i < c_ne; i++) if (m_v[d][i]) begin sum += m_cnt[d][i]; nv++; end
         ri = m_find(d, int'(req_id));
         es = (ri >= 0) ? (m_cnt[d][ri] == c_max) : (nv == c_ne);
         chk($sformatf("%s stall", p), 32'(d ? st_r : st_w), 32'(es));
         chk($sformatf("%s reset_req", p), 32'(d ? rr_r : rr_w), 32'(m_err[d]));
         chk($sformatf("%s irq", p), 32'(d ? irq_r : irq_w), 32'(m_err[d]));
         chk($sformatf("%s cause", p), 32'(d ? ca_r : ca_w), 32'(m_cause[d]));
         chk($sformatf("%s err_id", p), 32'(d ? ei_r : ei_w), 32'(m_eid[d]));
         chk($sformatf("%s outstanding", p), 32'(d ? out_r : out_w), 32'(sum));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_req(input int id);
      req_valid = 1'b1; req_ready = 1'b1; req_id = 4'(id);
      cyc(1);
      req_valid = 1'b0; req_ready = 1'b0;
   endtask

   task automatic do_rsp(input int id, input bit last);
      rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_id = 4'(id); rsp_last = last;
      cyc(1);
      rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_last = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   initial begin
      cyc(2);
      chk("reset outstanding", 32'(out_w), 32'd0);
      chk("reset reset_req", 32'(rr_w), 32'd0);
      rst = 1'b0;
      cyc(1);

      // completion in cycle 4 of a 5-tick budget
      do_req(3);
      chk("t1 outstanding after req", 32'(out_w), 32'd1);
      cyc(3);
      do_rsp(3, 1'b1);
      chk("t1 outstanding after rsp", 32'(out_w), 32'd0);
      cyc(5);
      chk("t1 no error", 32'(rr_w), 32'd0);

      // no response: timeout visible in cycle 6
      do_req(3);
      cyc(4);
      chk("t2 cycle5 no error", 32'(rr_w), 32'd0);
      cyc(1);
      chk("t2 reset_req", 32'(rr_w), 32'd1);
      chk("t2 irq", 32'(irq_w), 32'd1);
      chk("t2 cause", 32'(ca_w), 32'd1);
      chk("t2 err_id", 32'(ei_w), 32'd3);
      do_clear();
      chk("t2 clear reset_req", 32'(rr_w), 32'd0);
      chk("t2 clear cause", 32'(ca_w), 32'd0);
      chk("t2 clear outstanding", 32'(out_w), 32'd0);

      // read mode: only last beats complete, each completion reloads the budget
      do_req(2); do_req(2); do_req(2);
      chk("t3 rd outstanding 3", 32'(out_r), 32'd3);
      do_rsp(2, 1'b0); do_rsp(2, 1'b0); do_rsp(2, 1'b1);
      chk("t3 rd outstanding 2", 32'(out_r), 32'd2);
      cyc(1);
      do_rsp(2, 1'b0); do_rsp(2, 1'b0);
      chk("t3 rd non-last beats", 32'(out_r), 32'd2);
      do_rsp(2, 1'b1);
      chk("t3 rd outstanding 1", 32'(out_r), 32'd1);
      cyc(1);
      do_rsp(2, 1'b0); do_rsp(2, 1'b0); do_rsp(2, 1'b1);
      chk("t3 rd outstanding 0", 32'(out_r), 32'd0);
      chk("t3 rd no timeout", 32'(rr_r), 32'd0);
      do_clear();

      // fill all entries, then overflow on a new ID
      budget = 16'd100;
      for (int id = 0; id < 8; id++) do_req(id);
      chk("t4 outstanding 8", 32'(out_w), 32'd8);
      req_id = 4'd8; req_valid = 1'b1; #1;
      chk("t4 stall new id", 32'(st_w), 32'd1);
      req_id = 4'd3; #1;
      chk("t4 no stall known id", 32'(st_w), 32'd0);
      req_id = 4'd8;
      do_req(8);
      chk("t4 overflow cause", 32'(ca_w), 32'd3);
      chk("t4 overflow err_id", 32'(ei_w), 32'd8);
      chk("t4 outstanding held", 32'(out_w), 32'd8);
      do_clear();

      // unexpected response, then timeout outranking an unexpected one
      budget = 16'd5;
      do_rsp(5, 1'b1);
      chk("t5 unexpected cause", 32'(ca_w), 32'd2);
      chk("t5 unexpected err_id", 32'(ei_w), 32'd5);
      do_clear();
      do_req(1);
      cyc(4);
      do_rsp(5, 1'b1);
      chk("t5 priority cause", 32'(ca_w), 32'd1);
      chk("t5 priority err_id", 32'(ei_w), 32'd1);
      do_clear();

      // same-ID request and completion at count 1: entry stays, budget reloaded
      do_req(4);
      cyc(2);
      req_valid = 1'b1; req_ready = 1'b1; req_id = 4'd4;
      do_rsp(4, 1'b1);
      req_valid = 1'b0; req_ready = 1'b0;
      chk("t6 outstanding 1", 32'(out_w), 32'd1);
      cyc(4);
      chk("t6 reload no early timeout", 32'(rr_w), 32'd0);
      cyc(1);
      chk("t6 reloaded timeout", 32'(rr_w), 32'd1);
      chk("t6 err_id", 32'(ei_w), 32'd4);
      do_clear();

      // prescaled timeout
      prescale = 4'd2; budget = 16'd2;
      do_req(9);
      cyc(8);
      chk("t7 prescaled timeout", 32'(ca_w), 32'd1);
      chk("t7 prescaled err_id", 32'(ei_w), 32'd9);
      do_clear();
      prescale = 4'd0; budget = 16'd5;

      // asynchronous reset mid-transaction
      do_req(6);
      do_rsp(12, 1'b1);
      chk("t8 pre-reset error", 32'(rr_w), 32'd1);
      chk("t8 pre-reset outstanding", 32'(out_w), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t8 async reset_req", 32'(rr_w), 32'd0);
      chk("t8 async cause", 32'(ca_w), 32'd0);
      chk("t8 async outstanding", 32'(out_w), 32'd0);
      cyc(1);
      rst = 1'b0;
      cyc(1);
      do_rsp(6, 1'b1);
      chk("t8 table empty", 32'(ca_w), 32'd2);
      cyc(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
